// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator.
// Contents: FSM state encoding, per-column lane width, default widths,
//           and the packed mode word latched at start.
package psum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of one column sum when the fusion unit runs split.
  localparam int LANE_W = 9;

  localparam int PSUM_W_DEF = 18;
  localparam int ACC_W_DEF  = 32;
  localparam int LEN_W_DEF  = 8;

  // Arithmetic mode captured when an accumulation starts.
  typedef struct packed {
    logic sign;
    logic split_column;
  } mode_t;

endpackage

// File: rtl/psum_accumulator_lane_extend.sv
// Purpose: turn one partial-sum beat into the two ACC_W-wide addends.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: psum (raw beat), sign (1 = two's complement), split_column
//        (1 = two independent lanes); add_lo / add_hi are the addends.
module psum_accumulator_lane_extend
  import psum_accumulator_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [PSUM_W-1:0] psum,
  input  logic              sign,
  input  logic              split_column,
  output logic [ACC_W-1:0]  add_lo,
  output logic [ACC_W-1:0]  add_hi
);

  // Upper lane takes whatever is left above the low column.
  localparam int HI_W = PSUM_W - LANE_W;

  logic lo_msb;
  logic hi_msb;
  logic full_msb;

  // The extension bit is the lane's MSB only in signed mode.
  assign lo_msb   = sign & psum[LANE_W-1];
  assign hi_msb   = sign & psum[PSUM_W-1];
  assign full_msb = sign & psum[PSUM_W-1];

  always_comb begin
    add_lo = '0;
    add_hi = '0;
    if (split_column) begin
      add_lo = {{(ACC_W-LANE_W){lo_msb}}, psum[LANE_W-1:0]};
      add_hi = {{(ACC_W-HI_W){hi_msb}}, psum[PSUM_W-1:LANE_W]};
    end else begin
      add_lo = {{(ACC_W-PSUM_W){full_msb}}, psum};
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Purpose: accumulate acc_len partial-sum beats (fused or two-lane split,
//          signed or unsigned) and present the totals on a valid/ready port.
// Latency: out_valid rises the cycle after the last beat is accepted.
// Backpressure: psum_ready only in ACCUM; result held until out_ready.
// Ports: start/start_ready + acc_len/sign/split_column (job config),
//        psum_in/psum_valid/psum_ready (beats), out_lo/out_hi/out_valid/
//        out_ready (result), busy (not idle).
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              start_ready,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic              sign,
  input  logic              split_column,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic [ACC_W-1:0]  out_lo,
  output logic [ACC_W-1:0]  out_hi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  mode_t              mode_q;
  logic [ACC_W-1:0]   acc_lo;
  logic [ACC_W-1:0]   acc_hi;
  logic [ACC_W-1:0]   add_lo;
  logic [ACC_W-1:0]   add_hi;
  logic               start_fire;
  logic               beat_fire;
  logic               last_beat;
  logic               len_zero;

  psum_accumulator_lane_extend #(
    .PSUM_W (PSUM_W),
    .ACC_W  (ACC_W)
  ) u_lane_extend (
    .psum         (psum_in),
    .sign         (mode_q.sign),
    .split_column (mode_q.split_column),
    .add_lo       (add_lo),
    .add_hi       (add_hi)
  );

  // len_q is never zero while in ACCUM, so the subtraction cannot wrap there.
  assign last_beat  = (cnt == (len_q - LEN_W'(1)));
  assign len_zero   = (acc_len == '0);
  assign start_fire = start & start_ready;
  assign beat_fire  = psum_valid & psum_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b1;
    start_ready = 1'b0;
    psum_ready  = 1'b0;
    out_valid   = 1'b0;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        start_ready = 1'b1;
        if (start) begin
          state_nxt = len_zero ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        psum_ready = 1'b1;
        if (psum_valid && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // A new job may only be taken in the same cycle the result leaves.
        if (out_ready) begin
          start_ready = 1'b1;
          if (start) begin
            state_nxt = len_zero ? DONE : ACCUM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q  <= '0;
      cnt    <= '0;
      mode_q <= '0;
      acc_lo <= '0;
      acc_hi <= '0;
    end else if (start_fire) begin
      len_q               <= acc_len;
      mode_q.sign         <= sign;
      mode_q.split_column <= split_column;
      cnt                 <= '0;
      acc_lo              <= '0;
      acc_hi              <= '0;
    end else if (beat_fire) begin
      // Modulo 2^ACC_W wrap is intended: no saturation.
      acc_lo <= acc_lo + add_lo;
      acc_hi <= acc_hi + add_hi;
      cnt    <= cnt + LEN_W'(1);
    end
  end

  assign out_lo = acc_lo;
  assign out_hi = acc_hi;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a job-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_psum_accumulator;

  localparam int PSUM_W = 18;
  localparam int ACC_W  = 32;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              start_ready;
  logic [LEN_W-1:0]  acc_len = '0;
  logic              sign = 1'b0;
  logic              split_column = 1'b0;
  logic [PSUM_W-1:0] psum_in = '0;
  logic              psum_valid = 1'b0;
  logic              psum_ready;
  logic [ACC_W-1:0]  out_lo;
  logic [ACC_W-1:0]  out_hi;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;

  int checks = 0;
  int errors = 0;

  psum_accumulator #(
    .PSUM_W (PSUM_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_ready  (start_ready),
    .acc_len      (acc_len),
    .sign         (sign),
    .split_column (split_column),
    .psum_in      (psum_in),
    .psum_valid   (psum_valid),
    .psum_ready   (psum_ready),
    .out_lo       (out_lo),
    .out_hi       (out_hi),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level model ----------------
  // Extend a w-bit raw field to a signed integer when sg is set.
  function automatic longint ext(input longint raw, input int w, input bit sg);
    longint v;
    v = raw & ((longint'(1) << w) - 1);
    if (sg && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  longint      m_lo = 0;
  longint      m_hi = 0;
  int          m_left = 0;     // beats still owed to the current job
  bit          m_have = 0;     // a finished result is waiting to leave
  bit          m_sign = 0;
  bit          m_split = 0;
  int          handoffs = 0;
  bit          e_busy;
  bit          e_sr;
  logic [31:0] e_lo;
  logic [31:0] e_hi;

  always @(negedge clk) begin
    if (reset) begin
      m_lo = 0; m_hi = 0; m_left = 0; m_have = 0;
    end else begin
      e_busy = m_have || (m_left > 0);
      e_sr   = !e_busy || (m_have && out_ready);
      e_lo   = m_lo[31:0];
      e_hi   = m_hi[31:0];
      chk("model out_valid", out_valid, m_have);
      chk("model psum_ready", psum_ready, (m_left > 0) && !m_have);
      chk("model busy", busy, e_busy);
      chk("model start_ready", start_ready, e_sr);
      if (m_have) begin
        chk("model out_lo", out_lo, e_lo);
        chk("model out_hi", out_hi, e_hi);
      end
      // Effects of the coming clock edge.
      if (m_have && out_ready) begin
        m_have = 0;
        handoffs++;
      end
      if (m_left > 0 && psum_valid) begin
        if (m_split) begin
          m_lo += ext(longint'(psum_in[8:0]), 9, m_sign);
          m_hi += ext(longint'(psum_in[17:9]), 9, m_sign);
        end else begin
          m_lo += ext(longint'(psum_in), 18, m_sign);
        end
        m_left--;
        if (m_left == 0) m_have = 1;
      end
      if (start && e_sr) begin
        m_sign  = sign;
        m_split = split_column;
        m_lo    = 0;
        m_hi    = 0;
        m_left  = int'(acc_len);
        if (acc_len == 0) m_have = 1;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input bit sg, input bit sp);
    int n;
    start = 1'b1; acc_len = LEN_W'(len); sign = sg; split_column = sp;
    n = 0;
    while (!start_ready && n < 50) begin tick(); n++; end
    if (n == 50) chk("start_ready timeout", 0, 1);
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [PSUM_W-1:0] v);
    int n;
    psum_in = v; psum_valid = 1'b1;
    n = 0;
    while (!psum_ready && n < 50) begin tick(); n++; end
    if (n == 50) chk("psum_ready timeout", 0, 1);
    tick();
    psum_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_lo", out_lo, 0);
    chk("reset out_hi", out_hi, 0);
    chk("reset psum_ready", psum_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset start_ready", start_ready, 1);

    // Unsigned fused.
    out_ready = 1'b1;
    do_start(3, 0, 0);
    send_beat(18'd100); send_beat(18'd200); send_beat(18'd5);
    chk("ufused out_valid next cycle", out_valid, 1);
    chk("ufused out_lo", out_lo, 305);
    chk("ufused out_hi", out_hi, 0);
    tick();
    chk("ufused handoff idle", busy, 0);

    // Signed fused.
    do_start(2, 1, 0);
    send_beat(18'h3FFFF); send_beat(18'h3FFFE);
    chk("sfused out_lo", out_lo, 32'hFFFFFFFD);
    chk("sfused out_hi", out_hi, 0);
    tick();

    // Signed split.
    do_start(2, 1, 1);
    send_beat({9'h1FF, 9'd4}); send_beat({9'd10, 9'h1FC});
    chk("ssplit out_lo", out_lo, 0);
    chk("ssplit out_hi", out_hi, 9);
    tick();

    // Unsigned split: lanes zero-extended.
    do_start(1, 0, 1);
    send_beat({9'h1FF, 9'h1FF});
    chk("usplit out_lo", out_lo, 511);
    chk("usplit out_hi", out_hi, 511);
    tick();

    // Stalls, ignored start in ACCUM, backpressure in DONE.
    out_ready = 1'b0;
    do_start(4, 0, 0);
    send_beat(18'd1);
    start = 1'b1; acc_len = '0; sign = 1'b1; split_column = 1'b1;
    tick(); tick();
    start = 1'b0;
    send_beat(18'd2);
    tick();
    send_beat(18'd3); send_beat(18'd4);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; acc_len = 8'd1; psum_valid = 1'b1; psum_in = 18'd123;
      chk("stall out_valid", out_valid, 1);
      chk("stall psum_ready", psum_ready, 0);
      chk("stall start_ready", start_ready, 0);
      chk("stall out_lo", out_lo, 10);
      tick();
    end
    start = 1'b0; psum_valid = 1'b0; out_ready = 1'b1;
    chk("stall out_lo final", out_lo, 10);
    tick();
    chk("stall released idle", busy, 0);

    // Back-to-back into a zero-length job.
    out_ready = 1'b0;
    do_start(1, 0, 0);
    send_beat(18'd42);
    chk("b2b first result", out_lo, 42);
    out_ready = 1'b1;
    start = 1'b1; acc_len = '0;
    tick();
    start = 1'b0;
    chk("zero-len out_valid", out_valid, 1);
    chk("zero-len out_lo", out_lo, 0);
    chk("zero-len out_hi", out_hi, 0);
    tick();

    // Reset in the middle of a job.
    do_start(4, 0, 1);
    send_beat(18'd1); send_beat(18'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out_lo", out_lo, 0);
    chk("midreset out_hi", out_hi, 0);
    chk("midreset busy", busy, 0);
    do_start(1, 0, 0);
    send_beat(18'd7);
    chk("post-reset out_lo", out_lo, 7);
    tick();

    // Longest job with the largest unsigned beat.
    do_start(255, 0, 0);
    for (int i = 0; i < 255; i++) send_beat(18'h3FFFF);
    chk("maxlen out_lo", out_lo, 66846465);
    tick();

    tick();
    chk("results handed off", handoffs, 9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream stage of the fusion unit. Consumes its registered partial-sum output (psum_fwd, 18 bits) one beat per cycle.
- Accumulates a programmed number of beats into wide accumulators, then presents the result on a valid/ready output.
- Supports the fusion unit's two modes:
  - fused: one 18-bit total per beat.
  - split_column: two independent 9-bit column sums packed as {col2, col1}.
- Supports signed and unsigned accumulation.

Parameters:
- PSUM_W, 18, input partial-sum width (two 9-bit lanes when split).
- ACC_W, 32, width of each accumulator lane.
- LEN_W, 8, width of the beat-count field.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a new accumulation; accepted only when start_ready=1
- start_ready  output  1  high in IDLE, or in DONE when out_ready=1
- acc_len  input  LEN_W  number of beats to accumulate; latched on start
- sign  input  1  1 = signed; latched on start
- split_column  input  1  1 = two 9-bit lanes, 0 = one 18-bit value; latched on start
- psum_in  input  PSUM_W  partial sum from the fusion unit
- psum_valid  input  1  psum_in valid this cycle
- psum_ready  output  1  beat accepted when psum_valid && psum_ready
- out_lo  output  ACC_W  lane-0 accumulator (whole result when not split)
- out_hi  output  ACC_W  lane-1 accumulator; 0 when not split
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, both accumulators=0, beat counter=0.
  - out_lo=0, out_hi=0, out_valid=0, psum_ready=0, busy=0.
  - Reset mid-operation discards partial sums and any pending result.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - On start: latch acc_len, sign and split_column; clear both accumulators; counter=0.
  - If acc_len!=0, go to ACCUM.
  - If acc_len==0, go straight to DONE with a zero result.
- ACCUM:
  - psum_ready=1.
  - On each accepted beat, add the extended lanes to the accumulators and increment the counter.
  - When the accepted beat is beat number acc_len (counter==acc_len-1), go to DONE.
  - Cycles with psum_valid=0 are stalls: no state change.
- Lane extension, split=0:
  - lane0 = psum_in[17:0], sign- or zero-extended to ACC_W per the latched sign bit.
  - lane1 add = 0.
- Lane extension, split=1:
  - lane0 = psum_in[8:0], lane1 = psum_in[17:9].
  - Each lane is independently sign- or zero-extended to ACC_W.
- Arithmetic: modulo 2^ACC_W. No saturation and no overflow flag.
- DONE:
  - out_valid=1; out_lo/out_hi hold the final accumulators, stable until the handshake.
  - psum_ready=0.
  - out_ready=1 and start=0: go to IDLE.
  - out_ready=1 and start=1: back-to-back; latch the new config, clear accumulators, go to ACCUM (or DONE if acc_len==0).
  - out_ready=0: start is ignored; start_ready=0.
- Latency: out_valid rises the cycle after the last beat is accepted. Maximum throughput is one beat per cycle plus one DONE cycle per result.
- Ignored inputs:
  - start while in ACCUM.
  - psum_valid while in IDLE or DONE (no beat is consumed).
- Changes to sign, split_column or acc_len after start have no effect until the next start.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - lane width constant (9);
  - default PSUM_W, ACC_W, LEN_W.
- One sub-module, lane_extend: combinational. Takes psum_in, sign and split_column; produces the two ACC_W-wide addends.
- Top level holds the FSM, counter and accumulators.

Test Plan:
- Unsigned fused:
  - Stimulus: sign=0, split=0, acc_len=3; beats 18'd100, 18'd200, 18'd5 with out_ready=1.
  - Response: out_lo=305, out_hi=0, out_valid exactly one cycle after the third beat.
- Signed fused:
  - Stimulus: sign=1, split=0, acc_len=2; beats 18'h3FFFF (-1), 18'h3FFFE (-2).
  - Response: out_lo=32'hFFFFFFFD (-3).
- Signed split:
  - Stimulus: sign=1, split=1, acc_len=2; beats {9'h1FF, 9'd4} and {9'd10, 9'h1FC}.
  - Response: out_lo=0 (4 + -4); out_hi=9 (-1 + 10).
- Stalls and backpressure:
  - Stimulus: acc_len=4 with psum_valid gaps; hold out_ready=0 for 5 cycles in DONE.
  - Response: result correct; outputs stable; psum_ready=0 and start ignored while stalled.
- Back-to-back and zero length:
  - Stimulus: in DONE assert out_ready=1 with start=1 and acc_len=0.
  - Response: first result handed off; next cycle out_valid=1 with out_lo=out_hi=0.
- Reset mid-operation:
  - Stimulus: assert reset after 2 of 4 beats.
  - Response: next cycle state=IDLE, out_valid=0, accumulators 0. A new run of acc_len=1 with beat 7 returns out_lo=7.
